// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Operand/result bundle for the nibble-serial add/subtract sequencer.
// The master side issues operations and the slave side (the sequencer) returns results.
interface nibble_serial_addsub_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;
  logic             overflow;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, carry_out, zero, overflow
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, carry_out, zero, overflow
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit slice reused over WIDTH/4 cycles, LS nibble first.
// Define NIBBLE_ADDSUB_OVF_EN to build the signed-overflow flag; otherwise overflow reads 0.
module full_adder_subtractor4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  input  logic       i_sub_en,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [3:0] w_b_eff;
  logic [4:0] w_total;

  assign w_b_eff = i_b ^ {4{i_sub_en}};
  assign w_total = {1'b0, i_a} + {1'b0, w_b_eff} + {4'b0000, i_cin};
  assign o_sum   = w_total[3:0];
  assign o_cout  = w_total[4];
endmodule

module nibble_serial_addsub_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  nibble_serial_addsub_ctrl_if.slave bus
);
  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_zero;
  logic             w_accept;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_result_next;

  full_adder_subtractor4 u_slice (
    .i_a      (r_a[3:0]),
    .i_b      (r_b[3:0]),
    .i_cin    (r_carry),
    .i_sub_en (r_op),
    .o_sum    (w_slice_sum),
    .o_cout   (w_slice_cout)
  );

  assign w_accept      = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last        = (r_state == S_RUN) && (r_cnt == CW'(NIB - 1));
  assign w_result_next = {w_slice_sum, r_sum[WIDTH-1:4]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last)   w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Operands shift right so the slice always sees the current nibble in bits [3:0];
  // sum nibbles enter at the top and reach their final place on the completion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_sum    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_op    <= bus.op_sub;
      r_cnt   <= '0;
      r_carry <= bus.op_sub;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 4;
      r_b     <= r_b >> 4;
      r_sum   <= w_result_next;
      r_carry <= w_slice_cout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_result <= w_result_next;
        r_cout   <= w_slice_cout;
        r_zero   <= (w_result_next == '0);
      end
    end
  end

`ifdef NIBBLE_ADDSUB_OVF_EN
  logic r_ovf;
  logic w_ovf_next;

  // On the last nibble r_a[3]/r_b[3] are the operand sign bits.
  assign w_ovf_next = (r_a[3] == (r_b[3] ^ r_op)) && (w_slice_sum[3] != r_a[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ovf <= 1'b0;
    else if (w_last) r_ovf <= w_ovf_next;
  end

  assign bus.overflow = r_ovf;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.result    = r_result;
  assign bus.carry_out = r_cout;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Self-checking bench for nibble_serial_addsub_ctrl: directed table, corner sequences, random ops.
module tb_nibble_serial_addsub_ctrl;
  localparam int unsigned W   = 32;
  localparam int          NIB = W / 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nibble_serial_addsub_ctrl_if #(.WIDTH(W)) bus ();

  nibble_serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        v;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on whole words.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       output logic [31:0] r, output logic c, output logic z, output logic v);
    logic [32:0] s;
    longint      sv;
    if (sub) begin
      r  = a - b;
      c  = (a >= b);
      sv = longint'($signed(a)) - longint'($signed(b));
    end else begin
      s  = {1'b0, a} + {1'b0, b};
      r  = s[31:0];
      c  = s[32];
      sv = longint'($signed(a)) + longint'($signed(b));
    end
    z = (r == 32'd0);
`ifdef NIBBLE_ADDSUB_OVF_EN
    v = (sv > longint'(32'sh7FFFFFFF)) || (sv < longint'(32'sh80000000));
`else
    v = 1'b0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    bus.start  = 1'b1;
    bus.a      = a;
    bus.b      = b;
    bus.op_sub = sub;
    step();
    bus.start  = 1'b0;
    bus.a      = $urandom;
    bus.b      = $urandom;
    bus.op_sub = 1'($urandom_range(0, 1));
  endtask

  // Entered in cycle 1; returns in the DONE cycle. inj>0 pulses start during that RUN cycle.
  task automatic finish_op(input string name, input logic [31:0] er, input logic ec,
                           input logic ez, input logic ev, input int inj);
    for (int c = 1; c <= NIB; c++) begin
      chk({name, " busy/done in run"}, {62'd0, bus.busy, bus.done}, 64'd2);
      chk({name, " result held"}, {32'd0, bus.result}, {32'd0, last_res});
      if (c == inj) begin
        bus.start  = 1'b1;
        bus.a      = 32'd1;
        bus.b      = 32'd1;
        bus.op_sub = 1'b0;
      end
      step();
      if (c == inj) bus.start = 1'b0;
    end
    chk({name, " busy/done at done"}, {62'd0, bus.busy, bus.done}, 64'd1);
    chk({name, " result"}, {32'd0, bus.result}, {32'd0, er});
    chk({name, " carry_out"}, {63'd0, bus.carry_out}, {63'd0, ec});
    chk({name, " zero"}, {63'd0, bus.zero}, {63'd0, ez});
    chk({name, " overflow"}, {63'd0, bus.overflow}, {63'd0, ev});
    last_res = er;
  endtask

  task automatic chk_idle(input string name);
    step();
    chk({name, " idle busy/done"}, {62'd0, bus.busy, bus.done}, 64'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " busy/done"}, {62'd0, bus.busy, bus.done}, 64'd0);
    chk({name, " result"}, {32'd0, bus.result}, 64'd0);
    chk({name, " flags"}, {61'd0, bus.carry_out, bus.zero, bus.overflow}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, er;
    logic        rs, ec, ez, ev, b2b, ovf_exp;
    int          inj;

    tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    foreach (tbl[i]) begin
`ifdef NIBBLE_ADDSUB_OVF_EN
      ovf_exp = tbl[i].v;
`else
      ovf_exp = 1'b0;
`endif
      start_op(tbl[i].a, tbl[i].b, tbl[i].sub);
      finish_op($sformatf("vec%0d", i), tbl[i].res, tbl[i].c, tbl[i].z, ovf_exp, 0);
      chk_idle($sformatf("vec%0d", i));
    end

    // start during RUN is ignored; start during DONE chains with no idle gap
    start_op(32'h10, 32'h20, 1'b0);
    finish_op("ignore_start", 32'h30, 1'b0, 1'b0, 1'b0, 3);
    start_op(32'h1, 32'h1, 1'b0);
    finish_op("back_to_back", 32'h2, 1'b0, 1'b0, 1'b0, 0);
    chk_idle("back_to_back");

    // reset in cycle 4 discards the operation
    start_op(32'h0001_0000, 32'h1, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    last_res = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_idle("post_reset");
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    finish_op("after_reset", 32'h2345_6789, 1'b0, 1'b0, 1'b0, 0);
    chk_idle("after_reset");

    b2b = 1'b0;
    for (int n = 0; n < 40; n++) begin
      ra  = $urandom;
      rb  = $urandom;
      rs  = 1'($urandom_range(0, 1));
      if (n % 5 == 0) rb = ra;
      if (n % 7 == 0) rb = ~ra;
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NIB)) : 0;
      model(ra, rb, rs, er, ec, ez, ev);
      start_op(ra, rb, rs);
      finish_op($sformatf("rand%0d", n), er, ec, ez, ev, inj);
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) chk_idle($sformatf("rand%0d", n));
    end
    if (b2b) chk_idle("rand_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
